regfile_wr_arbiter: RTL

//  Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters:
//  req0 = ALU writeback, req1 = load/multicycle writeback.
//  - One-entry holding slot per requester; valid/ready handshake on each input.
//  - Round-robin grant, with a same-address ordering rule.
//  - Exports a pending-write mask so decode/hazard logic can stall reads of in-flight registers.

---
 rtl/rf_pkg.sv | 28 ++
 rtl/rf_wr_slot.sv | 51 +++++
 rtl/regfile_wr_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    localparam int unsigned AGE_W = 4;

    typedef logic req_idx_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_t;

    // At most two stamps are live, so the sign of the modular difference orders them.
    function automatic logic age_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] diff;
        diff = a - b;
        return diff[AGE_W-1];
    endfunction

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry write holding slot: valid/ready handshake, age stamp, drops writes to register 0.
module rf_wr_slot
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [AGE_W-1:0]  age_i,
    input  logic              grant_i,
    output logic              ready_o,
    output logic              accept_o,
    output logic              full_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [AGE_W-1:0]  age_o
);

    logic              full_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [AGE_W-1:0]  age_q;

    assign ready_o  = !full_q || grant_i;
    assign accept_o = valid_i && ready_o;
    assign full_o   = full_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign age_o    = age_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            age_q  <= '0;
        end else if (accept_o) begin
            full_q <= (addr_i != ADDR_W'(REG_ZERO));
            addr_q <= addr_i;
            data_q <= data_i;
            age_q  <= age_i;
        end else if (grant_i) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates two writeback slots onto the register file's single write port
// and publishes a mask of registers with writes still in flight.
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ADDR_W-1:0]    req0_addr,
    input  logic [DATA_W-1:0]    req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ADDR_W-1:0]    req1_addr,
    input  logic [DATA_W-1:0]    req1_data,
    output logic                 we3,
    output logic [ADDR_W-1:0]    wa3,
    output logic [DATA_W-1:0]    wd3,
    output logic [2**ADDR_W-1:0] pend_mask
);

    logic              full0, full1, acc0, acc1, grant0, grant1, any_full;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic [AGE_W-1:0]  age0, age1, age1_in, age_q, age_d;
    req_idx_t          gnt_idx;
    rr_t               rr_q, rr_d;
    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] wa3_q, wa3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;

    // A same-cycle req1 accept is stamped younger than req0's.
    assign age1_in = age_q + AGE_W'(acc0);
    assign age_d   = age1_in + AGE_W'(acc1);

    rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
        .clk(clk), .reset_n(reset_n),
        .valid_i(req0_valid), .addr_i(req0_addr), .data_i(req0_data),
        .age_i(age_q), .grant_i(grant0),
        .ready_o(req0_ready), .accept_o(acc0), .full_o(full0),
        .addr_o(addr0), .data_o(data0), .age_o(age0)
    );

    rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
        .clk(clk), .reset_n(reset_n),
        .valid_i(req1_valid), .addr_i(req1_addr), .data_i(req1_data),
        .age_i(age1_in), .grant_i(grant1),
        .ready_o(req1_ready), .accept_o(acc1), .full_o(full1),
        .addr_o(addr1), .data_o(data1), .age_o(age1)
    );

    always_comb begin
        any_full = full0 || full1;
        gnt_idx  = full1;
        rr_d     = rr_q;
        if (full0 && full1) begin
            if (addr0 == addr1) begin
                gnt_idx = age_older(age1, age0);
            end else begin
                gnt_idx = (rr_q == RR_REQ1);
            end
            rr_d = gnt_idx ? RR_REQ0 : RR_REQ1;
        end
        grant0 = any_full && !gnt_idx;
        grant1 = any_full && gnt_idx;

        we3_d = any_full;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (any_full) begin
            wa3_d = gnt_idx ? addr1 : addr0;
            wd3_d = gnt_idx ? data1 : data0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            age_q <= '0;
            rr_q  <= RR_REQ0;
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
        end else begin
            age_q <= age_d;
            rr_q  <= rr_d;
            we3_q <= we3_d;
            wa3_q <= wa3_d;
            wd3_q <= wd3_d;
        end
    end

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;

    always_comb begin
        pend_mask = '0;
        if (full0) pend_mask[addr0] = 1'b1;
        if (full1) pend_mask[addr1] = 1'b1;
        if (we3_q) pend_mask[wa3_q] = 1'b1;
    end

endmodule
